fifo_uart_tx: RTL

//  Downstream consumer of the byte FIFO: pops words when the FIFO is non-empty and

---
 rtl/fifo_uart_tx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a first-word-fall-through FIFO and sends each
// one as an asynchronous UART frame (start, DBIT data bits LSB-first, stop).
// A 16x-oversample baud tick is generated locally from the system clock.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit between
// the last data bit and the stop bit.
module fifo_uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 326,
    parameter int DVSR_W  = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd,
    output logic            tx,
    output logic            tx_busy
);

    // Tick counter must reach both 15 (start/data/parity) and SB_TICK-1 (stop).
    localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int S_W   = $clog2(S_MAX);
    localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state_reg, state_next;
    logic [DVSR_W-1:0] baud_reg, baud_next;
    logic [S_W-1:0]    s_reg, s_next;
    logic [N_W-1:0]    n_reg, n_next;
    logic [DBIT-1:0]   b_reg, b_next;
    logic              tx_reg, tx_next;
    logic              s_tick;
`ifdef UART_TX_PARITY_EN
    logic              parity_reg, parity_next;
`endif

    assign s_tick  = (baud_reg == DVSR_W'(DVSR - 1));
    assign tx      = tx_reg;
    assign tx_busy = rd | (state_reg != IDLE);

    // State and datapath registers; tx is registered so the line never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            baud_reg   <= '0;
            s_reg      <= '0;
            n_reg      <= '0;
            b_reg      <= '0;
            tx_reg     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            s_reg      <= s_next;
            n_reg      <= n_next;
            b_reg      <= b_next;
            tx_reg     <= tx_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    // Next-state logic: pop in IDLE, then walk start/data/(parity)/stop on ticks.
    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        rd         = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        // Held at zero while idle so the first bit of a frame is full length.
        if (state_reg == IDLE) begin
            baud_next = '0;
        end else if (s_tick) begin
            baud_next = '0;
        end else begin
            baud_next = baud_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (!empty && !reset) begin
                    rd         = 1'b1;
                    b_next     = r_data;
                    s_next     = '0;
                    state_next = START;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^r_data;
`endif
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == S_W'(15)) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = DATA;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == S_W'(15)) begin
                        s_next = '0;
                        b_next = b_reg >> 1;
                        if (n_reg == N_W'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n_reg + 1'b1;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_reg == S_W'(15)) begin
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_reg == S_W'(SB_TICK - 1)) begin
                        s_next     = '0;
                        state_next = IDLE;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level for the state being entered, so tx changes on the same edge.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = b_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

endmodule
